// File: rtl/l2switch_pkg.sv
// l2switch_pkg: XGMII constants, 72-bit word helpers and frame-mux state enum.
package l2switch_pkg;
    localparam int WORD_W = 72;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [WORD_W-1:0] IDLE_WORD  = {8'hFF, {8{XGMII_IDLE}}};
    localparam logic [WORD_W-1:0] ERROR_WORD = {8'hFF, {8{XGMII_ERROR}}};

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DRAIN, ST_GAP} state_e;

    // Word layout is {rxc[7:0], rxd[63:0]}; start lives in lane 0 only.
    function automatic logic is_start(input logic [WORD_W-1:0] w);
        return w[64] && (w[7:0] == XGMII_START);
    endfunction

    function automatic logic is_term(input logic [WORD_W-1:0] w);
        logic t;
        t = 1'b0;
        for (int i = 0; i < 8; i++) t = t | (w[64+i] && (w[8*i +: 8] == XGMII_TERM));
        return t;
    endfunction
endpackage

// File: rtl/l2sw_frame_mux_if.sv
// l2sw_frame_mux_if: ingress FIFO heads/pops, egress write port and status of the frame mux.
interface l2sw_frame_mux_if #(parameter int NPORTS = 4);
    import l2switch_pkg::*;
    logic [NPORTS-1:0]        port_en;
    logic [WORD_W*NPORTS-1:0] in_dout;
    logic [NPORTS-1:0]        in_empty;
    logic [NPORTS-1:0]        in_rd_en;
    logic [WORD_W-1:0]        out_din;
    logic                     out_wr_en;
    logic                     out_full;
    logic [2:0]               cur_port;
    logic [31:0]              frame_cnt;
    logic [15:0]              abort_cnt;

    modport master (
        output port_en, in_dout, in_empty, out_full,
        input  in_rd_en, out_din, out_wr_en, cur_port, frame_cnt, abort_cnt
    );
    modport slave (
        input  port_en, in_dout, in_empty, out_full,
        output in_rd_en, out_din, out_wr_en, cur_port, frame_cnt, abort_cnt
    );
endinterface

// File: rtl/l2sw_rr_arbiter.sv
// l2sw_rr_arbiter: round-robin pick of the first requester after the last grant, wrapping at N-1.
module l2sw_rr_arbiter #(parameter int N = 4) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   last_i,
    output logic [N-1:0] gnt_o,
    output logic         valid_o
);
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++)
            for (int p = 0; p < N; p++)
                if (!found && req_i[p] && p == (int'(last_i) + k) % N) begin
                    gnt_o[p] = 1'b1;
                    found = 1'b1;
                end
    end

    assign valid_o = found;
endmodule

// File: rtl/l2sw_frame_mux.sv
// l2sw_frame_mux: round-robin N:1 XGMII frame multiplexer with abort on oversize and inter-frame idles.
// Optional statistics counters are built only with L2SW_STATS_EN defined.
module l2sw_frame_mux import l2switch_pkg::*; #(
    parameter int NPORTS    = 4,
    parameter int IDLE_GAP  = 2,
    parameter int MAX_WORDS = 192
) (
    input logic sys_clk,
    input logic sys_rst_n,
    l2sw_frame_mux_if.slave bus
);
    localparam state_e AFTER = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;

    state_e            state_q, state_d;
    logic [2:0]        cur_q, cur_d;
    logic [9:0]        wcnt_q, wcnt_d;
    logic [3:0]        gap_q, gap_d;
    logic [WORD_W-1:0] head [NPORTS];
    logic [WORD_W-1:0] cur_head;
    logic [NPORTS-1:0] start_v, req, gnt, cur_sel, rd_en;
    logic [2:0]        gnt_idx;
    logic              gnt_v, cur_empty, cur_term, abort_hit, gap_done;
    logic              frame_done, abort_fire, wr_en;
    logic [WORD_W-1:0] din;

    genvar g;
    for (g = 0; g < NPORTS; g++) begin : g_head
        assign head[g]    = bus.in_dout[WORD_W*g +: WORD_W];
        assign start_v[g] = is_start(head[g]);
    end

    assign req = bus.port_en & ~bus.in_empty & start_v;

    l2sw_rr_arbiter #(.N(NPORTS)) u_arb (
        .req_i   (req),
        .last_i  (cur_q),
        .gnt_o   (gnt),
        .valid_o (gnt_v)
    );

    always_comb begin
        gnt_idx   = '0;
        cur_head  = '0;
        cur_empty = 1'b1;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt[p]) gnt_idx = 3'(p);
            if (cur_q == 3'(p)) begin
                cur_head  = head[p];
                cur_empty = bus.in_empty[p];
            end
        end
    end

    assign cur_sel   = {{(NPORTS-1){1'b0}}, 1'b1} << cur_q;
    assign cur_term  = is_term(cur_head);
    assign abort_hit = (wcnt_q == 10'(MAX_WORDS));
    assign gap_done  = (gap_q == 4'(IDLE_GAP - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= 3'(NPORTS - 1);
            wcnt_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            wcnt_q  <= wcnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        wcnt_d     = wcnt_q;
        gap_d      = gap_q;
        frame_done = 1'b0;
        abort_fire = 1'b0;
        case (state_q)
            ST_IDLE: if (gnt_v) begin
                cur_d   = gnt_idx;
                wcnt_d  = '0;
                state_d = ST_FWD;
            end
            ST_FWD: if (abort_hit) begin
                abort_fire = !bus.out_full;
                state_d    = bus.out_full ? ST_FWD : ST_DRAIN;
            end else if (!cur_empty && !bus.out_full) begin
                wcnt_d     = wcnt_q + 10'd1;
                frame_done = cur_term;
                state_d    = cur_term ? AFTER : ST_FWD;
            end
            ST_DRAIN: state_d = (!cur_empty && cur_term) ? AFTER : ST_DRAIN;
            ST_GAP: if (!bus.out_full) begin
                gap_d   = gap_done ? 4'd0 : gap_q + 4'd1;
                state_d = gap_done ? ST_IDLE : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Idle discards: anything at a head that cannot start a forwarded frame is dropped.
    always_comb begin
        rd_en = '0;
        wr_en = 1'b0;
        din   = cur_head;
        case (state_q)
            ST_IDLE:  rd_en = ~bus.in_empty & ~(start_v & bus.port_en);
            ST_FWD: if (abort_hit) begin
                wr_en = !bus.out_full;
                din   = ERROR_WORD;
            end else if (!cur_empty && !bus.out_full) begin
                wr_en = 1'b1;
                rd_en = cur_sel;
            end
            ST_DRAIN: rd_en = cur_empty ? '0 : cur_sel;
            ST_GAP: begin
                wr_en = !bus.out_full;
                din   = IDLE_WORD;
            end
            default: rd_en = '0;
        endcase
    end

    assign bus.in_rd_en  = rd_en & {NPORTS{sys_rst_n}};
    assign bus.out_wr_en = wr_en & sys_rst_n;
    assign bus.out_din   = din;
    assign bus.cur_port  = cur_q;

`ifdef L2SW_STATS_EN
    logic [31:0] frame_q;
    logic [15:0] abort_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_q <= '0;
            abort_q <= '0;
        end else begin
            frame_q <= frame_q + 32'(frame_done);
            abort_q <= abort_q + 16'(abort_fire && abort_q != 16'hFFFF);
        end
    end

    assign bus.frame_cnt = frame_q;
    assign bus.abort_cnt = abort_q;
`else
    logic unused_stats;
    assign unused_stats  = frame_done ^ abort_fire;
    assign bus.frame_cnt = '0;
    assign bus.abort_cnt = '0;
`endif
endmodule

// File: tb/tb_l2sw_frame_mux.sv
// tb_l2sw_frame_mux: directed bench with FWFT ingress FIFO models and an egress capture log.
module tb_l2sw_frame_mux;
    import l2switch_pkg::*;
`ifdef L2SW_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    l2sw_frame_mux_if #(.NPORTS(4)) bus();

    l2sw_frame_mux #(.NPORTS(4), .IDLE_GAP(2), .MAX_WORDS(192)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    logic [71:0] mem [4][1024];
    int          wp [4];
    int          rp [4];
    logic [71:0] oq [512];
    logic [2:0]  ocp [512];
    logic [71:0] ew [512];
    int          on, en, viol;
    int          checks, errors, exp_f, exp_a;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            bus.in_empty[p] = rp[p] >= wp[p];
            bus.in_dout[72*p +: 72] = (rp[p] < wp[p]) ? mem[p][rp[p][9:0]] : 72'h0;
        end
    end

    always @(posedge sys_clk) begin
        for (int p = 0; p < 4; p++)
            if (bus.in_rd_en[p]) begin
                rp[p] <= rp[p] + 1;
                if (rp[p] >= wp[p]) viol <= viol + 1;
            end
        if (bus.out_wr_en) begin
            oq[on[8:0]]  <= bus.out_din;
            ocp[on[8:0]] <= bus.cur_port;
            on <= on + 1;
            if (bus.out_full) viol <= viol + 1;
        end
    end

    function automatic logic [71:0] fw(input int tag, input int i, input int n);
        if (i == 0) return {8'h01, 8'(tag), 48'h0, 8'hFB};
        if (i == n - 1) return {8'h80, 8'hFD, 8'(tag), 32'h0, 16'(i)};
        return {8'h00, 8'(tag), 40'h0, 16'(i)};
    endfunction

    task automatic push(input int p, input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = wp[p];
            mem[p][k[9:0]] = fw(tag, i, n);
            wp[p] = wp[p] + 1;
        end
    endtask

    task automatic expect_frame(input int tag, input int n, input int keep);
        for (int i = 0; i < keep; i++) begin
            ew[en] = fw(tag, i, n);
            en++;
        end
    endtask

    task automatic expect_word(input logic [71:0] w);
        ew[en] = w;
        en++;
    endtask

    task automatic wait_out(input int target, input int budget, input string nm);
        int c;
        c = 0;
        while (on < target && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        checks++;
        if (on < target) begin
            errors++;
            $display("FAIL %s timeout: got %0d words, need %0d", nm, on, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        checks += 5;
        if (bus.cur_port !== 3'd3) begin errors++; $display("FAIL reset cur_port: got %0d, want 3", bus.cur_port); end
        if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL reset out_wr_en: got %b, want 0", bus.out_wr_en); end
        if (bus.in_rd_en !== 4'b0) begin errors++; $display("FAIL reset in_rd_en: got %b, want 0", bus.in_rd_en); end
        if (bus.frame_cnt !== 32'd0) begin errors++; $display("FAIL reset frame_cnt: got %0d, want 0", bus.frame_cnt); end
        if (bus.abort_cnt !== 16'd0) begin errors++; $display("FAIL reset abort_cnt: got %0d, want 0", bus.abort_cnt); end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_single();
        int base;
        base = on;
        en = 0;
        expect_frame(1, 10, 10);
        expect_word(IDLE_WORD);
        expect_word(IDLE_WORD);
        push(0, 1, 10);
        wait_out(base + 12, 60, "single");
        repeat (5) @(negedge sys_clk);
        exp_f++;
        for (int i = 0; i < en; i++) begin
            int k;
            k = base + i;
            checks++;
            if (oq[k[8:0]] !== ew[i]) begin errors++; $display("FAIL single word %0d: got %h, want %h", i, oq[k[8:0]], ew[i]); end
        end
        checks += 3;
        if (on !== base + 12) begin errors++; $display("FAIL single count: got %0d, want %0d", on - base, 12); end
        if (bus.cur_port !== 3'd0) begin errors++; $display("FAIL single cur_port: got %0d, want 0", bus.cur_port); end
        if (bus.frame_cnt !== (STATS ? 32'(exp_f) : 32'd0)) begin errors++; $display("FAIL single frame_cnt: got %0d, want %0d", bus.frame_cnt, STATS ? exp_f : 0); end
    endtask

    task automatic test_round_robin();
        int base;
        int starts [4];
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        exp_f = 0;
        base = on;
        en = 0;
        for (int p = 0; p < 4; p++) begin
            push(p, 16 + p, 5 + p);
            starts[p] = en;
            expect_frame(16 + p, 5 + p, 5 + p);
            expect_word(IDLE_WORD);
            expect_word(IDLE_WORD);
        end
        sys_rst_n = 1'b1;
        wait_out(base + en, 200, "rr");
        repeat (3) @(negedge sys_clk);
        exp_f += 4;
        for (int i = 0; i < en; i++) begin
            int k;
            k = base + i;
            checks++;
            if (oq[k[8:0]] !== ew[i]) begin errors++; $display("FAIL rr word %0d: got %h, want %h", i, oq[k[8:0]], ew[i]); end
        end
        for (int p = 0; p < 4; p++) begin
            int k;
            k = base + starts[p];
            checks++;
            if (ocp[k[8:0]] !== 3'(p)) begin errors++; $display("FAIL rr grant %0d: got port %0d, want %0d", p, ocp[k[8:0]], p); end
        end
        checks++;
        if (bus.frame_cnt !== (STATS ? 32'(exp_f) : 32'd0)) begin errors++; $display("FAIL rr frame_cnt: got %0d, want %0d", bus.frame_cnt, STATS ? exp_f : 0); end
    endtask

    task automatic test_backpressure();
        int base, on_b, rp_b;
        base = on;
        en = 0;
        expect_frame(32, 10, 10);
        expect_word(IDLE_WORD);
        expect_word(IDLE_WORD);
        push(1, 32, 10);
        wait_out(base + 4, 40, "bp start");
        bus.out_full = 1'b1;
        on_b = on;
        rp_b = rp[1];
        #1;
        checks += 2;
        if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL bp wr_en: got %b, want 0", bus.out_wr_en); end
        if (bus.in_rd_en !== 4'b0) begin errors++; $display("FAIL bp rd_en: got %b, want 0", bus.in_rd_en); end
        repeat (5) @(negedge sys_clk);
        checks += 2;
        if (on !== on_b) begin errors++; $display("FAIL bp writes: got %0d, want 0", on - on_b); end
        if (rp[1] !== rp_b) begin errors++; $display("FAIL bp pops: got %0d, want 0", rp[1] - rp_b); end
        bus.out_full = 1'b0;
        wait_out(base + 12, 60, "bp end");
        repeat (3) @(negedge sys_clk);
        exp_f++;
        for (int i = 0; i < en; i++) begin
            int k;
            k = base + i;
            checks++;
            if (oq[k[8:0]] !== ew[i]) begin errors++; $display("FAIL bp word %0d: got %h, want %h", i, oq[k[8:0]], ew[i]); end
        end
    endtask

    task automatic test_abort();
        int base;
        base = on;
        en = 0;
        expect_frame(48, 200, 192);
        expect_word(ERROR_WORD);
        expect_word(IDLE_WORD);
        expect_word(IDLE_WORD);
        push(2, 48, 200);
        wait_out(base + en, 500, "abort");
        repeat (5) @(negedge sys_clk);
        exp_a++;
        for (int i = 0; i < en; i++) begin
            int k;
            k = base + i;
            checks++;
            if (oq[k[8:0]] !== ew[i]) begin errors++; $display("FAIL abort word %0d: got %h, want %h", i, oq[k[8:0]], ew[i]); end
        end
        checks += 4;
        if (on !== base + en) begin errors++; $display("FAIL abort count: got %0d, want %0d", on - base, en); end
        if (rp[2] !== wp[2]) begin errors++; $display("FAIL abort drain: got %0d left, want 0", wp[2] - rp[2]); end
        if (bus.abort_cnt !== (STATS ? 16'(exp_a) : 16'd0)) begin errors++; $display("FAIL abort abort_cnt: got %0d, want %0d", bus.abort_cnt, STATS ? exp_a : 0); end
        if (bus.frame_cnt !== (STATS ? 32'(exp_f) : 32'd0)) begin errors++; $display("FAIL abort frame_cnt: got %0d, want %0d", bus.frame_cnt, STATS ? exp_f : 0); end
    endtask

    task automatic test_port_disable();
        int base;
        base = on;
        bus.port_en = 4'b1101;
        push(1, 64, 4);
        push(1, 65, 4);
        repeat (20) @(negedge sys_clk);
        checks += 2;
        if (rp[1] !== wp[1]) begin errors++; $display("FAIL disable discard: got %0d left, want 0", wp[1] - rp[1]); end
        if (on !== base) begin errors++; $display("FAIL disable output: got %0d words, want 0", on - base); end
        bus.port_en = 4'b1111;
    endtask

    task automatic test_midframe_reset();
        int base, mark;
        push(1, 80, 10);
        wait_out(on + 4, 40, "mid start");
        sys_rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.cur_port !== 3'd3) begin errors++; $display("FAIL mid cur_port: got %0d, want 3", bus.cur_port); end
        if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL mid wr_en: got %b, want 0", bus.out_wr_en); end
        if (bus.in_rd_en !== 4'b0) begin errors++; $display("FAIL mid rd_en: got %b, want 0", bus.in_rd_en); end
        exp_f = 0;
        base = on;
        en = 0;
        push(2, 82, 5);
        push(0, 81, 5);
        expect_frame(81, 5, 5);
        expect_word(IDLE_WORD);
        expect_word(IDLE_WORD);
        mark = en;
        expect_frame(82, 5, 5);
        expect_word(IDLE_WORD);
        expect_word(IDLE_WORD);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_out(base + en, 100, "mid end");
        repeat (10) @(negedge sys_clk);
        exp_f += 2;
        for (int i = 0; i < en; i++) begin
            int k;
            k = base + i;
            checks++;
            if (oq[k[8:0]] !== ew[i]) begin errors++; $display("FAIL mid word %0d: got %h, want %h", i, oq[k[8:0]], ew[i]); end
        end
        checks += 4;
        if (ocp[base[8:0]] !== 3'd0) begin errors++; $display("FAIL mid first grant: got %0d, want 0", ocp[base[8:0]]); end
        mark = base + mark;
        if (ocp[mark[8:0]] !== 3'd2) begin errors++; $display("FAIL mid second grant: got %0d, want 2", ocp[mark[8:0]]); end
        if (rp[1] !== wp[1]) begin errors++; $display("FAIL mid leftover: got %0d left, want 0", wp[1] - rp[1]); end
        if (bus.frame_cnt !== (STATS ? 32'(exp_f) : 32'd0)) begin errors++; $display("FAIL mid frame_cnt: got %0d, want %0d", bus.frame_cnt, STATS ? exp_f : 0); end
    endtask

    initial begin
        bus.port_en  = 4'hF;
        bus.out_full = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_port_disable();
        test_midframe_reset();
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL handshake: got %0d strobes on full/empty, want 0", viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
